clock_enable_gen: RTL and testbench



---
 rtl/clock_enable_gen.sv | 164 ++++++++++++++++
 tb/tb_clock_enable_gen.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_enable_gen.sv
// NUM_CH fractional-rate (MULT/DIV) clock enables from phase accumulators, with a lock
// sequencer and validated runtime reconfiguration. Define CE_PHASE_EN to add CFG_PHASE preload.
module clock_enable_gen #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned ACC_W       = 16,
    parameter int unsigned LOCK_CYCLES = 16,
    parameter int unsigned DEF_MULT    = 2,
    parameter int unsigned DEF_DIV     = 10
) (
    input  logic                    CLK_IN,
    input  logic                    RESET,
    input  logic                    CFG_LOAD,
    input  logic [NUM_CH*ACC_W-1:0] CFG_MULT,
    input  logic [NUM_CH*ACC_W-1:0] CFG_DIV,
`ifdef CE_PHASE_EN
    input  logic [NUM_CH*ACC_W-1:0] CFG_PHASE,
`endif
    output logic [NUM_CH-1:0]       CE_OUT,
    output logic                    LOCKED,
    output logic                    CFG_ERR,
    output logic [1:0]              STATUS
);

    typedef enum logic [1:0] {
        StRst  = 2'd0,
        StWait = 2'd1,
        StRun  = 2'd2,
        StErr  = 2'd3
    } state_e;

    localparam int unsigned CntW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CntW-1:0] LockLast = CntW'(LOCK_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              locked_q, locked_d;
    logic              err_q, err_d;
    logic [NUM_CH-1:0] ce_q, ce_d;

    logic [ACC_W-1:0]  mult_q [NUM_CH];
    logic [ACC_W-1:0]  mult_d [NUM_CH];
    logic [ACC_W-1:0]  div_q  [NUM_CH];
    logic [ACC_W-1:0]  div_d  [NUM_CH];
    logic [ACC_W-1:0]  acc_q  [NUM_CH];
    logic [ACC_W-1:0]  acc_d  [NUM_CH];

    logic [ACC_W-1:0]  ld_mult [NUM_CH];
    logic [ACC_W-1:0]  ld_div  [NUM_CH];
    logic [ACC_W-1:0]  ld_pre  [NUM_CH];
    logic [ACC_W:0]    sum     [NUM_CH];
    logic              cfg_ok;

    // Unpack the configuration buses and validate every channel at once.
    always_comb begin
        cfg_ok = 1'b1;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            ld_mult[ch] = CFG_MULT[ch*ACC_W +: ACC_W];
            ld_div[ch]  = CFG_DIV[ch*ACC_W +: ACC_W];
`ifdef CE_PHASE_EN
            ld_pre[ch]  = CFG_PHASE[ch*ACC_W +: ACC_W];
            if (ld_pre[ch] >= ld_div[ch]) begin
                cfg_ok = 1'b0;
            end
`else
            ld_pre[ch]  = '0;
`endif
            if ((ld_div[ch] == '0) || (ld_mult[ch] > ld_div[ch])) begin
                cfg_ok = 1'b0;
            end
        end
    end

    // One extra bit keeps acc + MULT exact; acc < DIV holds so the remainder fits ACC_W.
    always_comb begin
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            sum[ch] = {1'b0, acc_q[ch]} + {1'b0, mult_q[ch]};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        locked_d = locked_q;
        err_d    = err_q;
        ce_d     = '0;
        mult_d   = mult_q;
        div_d    = div_q;
        acc_d    = acc_q;

        if (CFG_LOAD) begin
            locked_d = 1'b0;
            if (cfg_ok) begin
                mult_d  = ld_mult;
                div_d   = ld_div;
                acc_d   = ld_pre;
                err_d   = 1'b0;
                cnt_d   = '0;
                state_d = StWait;
            end else begin
                err_d   = 1'b1;
                state_d = StErr;
            end
        end else begin
            unique case (state_q)
                // The edge leaving RST counts as the first lock edge.
                StRst, StWait: begin
                    if (cnt_q == LockLast) begin
                        state_d  = StRun;
                        locked_d = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
                StRun: begin
                    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                        if (sum[ch] >= {1'b0, div_q[ch]}) begin
                            acc_d[ch] = ACC_W'(sum[ch] - {1'b0, div_q[ch]});
                            ce_d[ch]  = 1'b1;
                        end else begin
                            acc_d[ch] = sum[ch][ACC_W-1:0];
                        end
                    end
                end
                StErr: begin
                    state_d = StErr;
                end
                default: begin
                    state_d = StRst;
                end
            endcase
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (RESET) begin
            state_q  <= StRst;
            cnt_q    <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            ce_q     <= '0;
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                mult_q[ch] <= ACC_W'(DEF_MULT);
                div_q[ch]  <= ACC_W'(DEF_DIV);
                acc_q[ch]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            ce_q     <= ce_d;
            mult_q   <= mult_d;
            div_q    <= div_d;
            acc_q    <= acc_d;
        end
    end

    assign CE_OUT  = ce_q;
    assign LOCKED  = locked_q;
    assign CFG_ERR = err_q;
    assign STATUS  = state_q;

endmodule

// File: tb/tb_clock_enable_gen.sv
// Randomized bench for clock_enable_gen against an arithmetic model: CE at run edge n fires
// when floor((P + n*M)/D) advances; lock, error and reset handled as per-edge bookkeeping.
module tb_clock_enable_gen;

    localparam int unsigned NUM_CH      = 2;
    localparam int unsigned ACC_W       = 16;
    localparam int unsigned LOCK_CYCLES = 16;

    logic                    CLK_IN = 1'b0;
    logic                    RESET;
    logic                    CFG_LOAD;
    logic [NUM_CH*ACC_W-1:0] CFG_MULT;
    logic [NUM_CH*ACC_W-1:0] CFG_DIV;
    logic [NUM_CH*ACC_W-1:0] CFG_PHASE;
    logic [NUM_CH-1:0]       CE_OUT;
    logic                    LOCKED;
    logic                    CFG_ERR;
    logic [1:0]              STATUS;

    clock_enable_gen #(
        .NUM_CH      (NUM_CH),
        .ACC_W       (ACC_W),
        .LOCK_CYCLES (LOCK_CYCLES),
        .DEF_MULT    (2),
        .DEF_DIV     (10)
    ) dut (
        .CLK_IN   (CLK_IN),
        .RESET    (RESET),
        .CFG_LOAD (CFG_LOAD),
        .CFG_MULT (CFG_MULT),
        .CFG_DIV  (CFG_DIV),
`ifdef CE_PHASE_EN
        .CFG_PHASE(CFG_PHASE),
`endif
        .CE_OUT   (CE_OUT),
        .LOCKED   (LOCKED),
        .CFG_ERR  (CFG_ERR),
        .STATUS   (STATUS)
    );

    always #5 CLK_IN = ~CLK_IN;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    longint            m_mult [NUM_CH];
    longint            m_div  [NUM_CH];
    longint            m_pre  [NUM_CH];
    int                m_status;
    int                m_wait;
    longint            m_run;
    bit                m_locked;
    bit                m_err;
    logic [NUM_CH-1:0] m_ce;

    function automatic longint bus_get(input logic [NUM_CH*ACC_W-1:0] bus, input int ch);
        logic [ACC_W-1:0] v;
        v = bus[ch*ACC_W +: ACC_W];
        return longint'(v);
    endfunction

    task automatic model_edge(input bit rst, input bit load);
        bit     ok;
        longint m, d, p, a, b;
        m_ce = '0;
        if (rst) begin
            m_status = 0;
            m_wait   = 0;
            m_run    = 0;
            m_locked = 1'b0;
            m_err    = 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                m_mult[ch] = 2;
                m_div[ch]  = 10;
                m_pre[ch]  = 0;
            end
        end else if (load) begin
            ok = 1'b1;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                m = bus_get(CFG_MULT, ch);
                d = bus_get(CFG_DIV, ch);
`ifdef CE_PHASE_EN
                p = bus_get(CFG_PHASE, ch);
`else
                p = 0;
`endif
                if (d == 0 || m > d || p >= d) ok = 1'b0;
            end
            m_locked = 1'b0;
            if (ok) begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    m_mult[ch] = bus_get(CFG_MULT, ch);
                    m_div[ch]  = bus_get(CFG_DIV, ch);
`ifdef CE_PHASE_EN
                    m_pre[ch]  = bus_get(CFG_PHASE, ch);
`else
                    m_pre[ch]  = 0;
`endif
                end
                m_status = 1;
                m_wait   = 0;
                m_run    = 0;
                m_err    = 1'b0;
            end else begin
                m_status = 3;
                m_err    = 1'b1;
            end
        end else if (m_status == 0 || m_status == 1) begin
            m_wait++;
            m_status = 1;
            if (m_wait == LOCK_CYCLES) begin
                m_status = 2;
                m_locked = 1'b1;
            end
        end else if (m_status == 2) begin
            m_run++;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                a = m_pre[ch] + m_run * m_mult[ch];
                b = m_pre[ch] + (m_run - 1) * m_mult[ch];
                m_ce[ch] = ((a / m_div[ch]) != (b / m_div[ch]));
            end
        end
    endtask

    task automatic noise();
        CFG_MULT  = {$urandom, $urandom};
        CFG_DIV   = {$urandom, $urandom};
        CFG_PHASE = {$urandom, $urandom};
    endtask

    task automatic set_ch(input int ch, input int unsigned m, input int unsigned d,
                          input int unsigned p);
        CFG_MULT[ch*ACC_W +: ACC_W]  = ACC_W'(m);
        CFG_DIV[ch*ACC_W +: ACC_W]   = ACC_W'(d);
        CFG_PHASE[ch*ACC_W +: ACC_W] = ACC_W'(p);
    endtask

    task automatic step(input bit rst, input bit load);
        RESET    = rst;
        CFG_LOAD = load;
        if (!load) noise();
        @(posedge CLK_IN);
        model_edge(rst, load);
        #1;
        check_val("ce_out", CE_OUT, m_ce);
        check_val("locked", LOCKED, m_locked);
        check_val("cfg_err", CFG_ERR, m_err);
        check_val("status", STATUS, m_status);
    endtask

    task automatic wait_lock(input string tag, input int exp);
        int found;
        found = -1;
        for (int k = 1; k <= 40; k++) begin
            step(1'b0, 1'b0);
            if (LOCKED) begin
                found = k;
                break;
            end
        end
        check_val(tag, found, exp);
    endtask

    task automatic run_cycles(input int n, output int cnt0, output int cnt1, output int first0,
                              output int min_gap0, output int max_gap0);
        int last0;
        cnt0 = 0; cnt1 = 0; first0 = -1; min_gap0 = 1 << 30; max_gap0 = 0; last0 = -1;
        for (int k = 1; k <= n; k++) begin
            step(1'b0, 1'b0);
            if (CE_OUT[1]) cnt1++;
            if (CE_OUT[0]) begin
                cnt0++;
                if (first0 < 0) first0 = k;
                if (last0 >= 0) begin
                    if (k - last0 < min_gap0) min_gap0 = k - last0;
                    if (k - last0 > max_gap0) max_gap0 = k - last0;
                end
                last0 = k;
            end
        end
    endtask

    initial begin
        int c0, c1, f0, gmin, gmax;
        int unsigned d, m, p;
        RESET = 1'b1;
        CFG_LOAD = 1'b0;
        noise();

        // Reset and default 2/10 ratio
        repeat (3) step(1'b1, 1'b0);
        check_val("rst_status", STATUS, 0);
        check_val("rst_ce", CE_OUT, 0);
        wait_lock("lock_after_reset", 16);
        run_cycles(100, c0, c1, f0, gmin, gmax);
        check_val("def_first_ce", f0, 5);
        check_val("def_count_ch0", c0, 20);
        check_val("def_count_ch1", c1, 20);

        // Reconfigure from RUN: 3/7 and 7/7
        set_ch(0, 3, 7, 0);
        set_ch(1, 7, 7, 0);
        step(1'b0, 1'b1);
        check_val("load_locked_drop", LOCKED, 0);
        wait_lock("relock_3_7", 16);
        run_cycles(70, c0, c1, f0, gmin, gmax);
        check_val("r37_count", c0, 30);
        check_val("r37_gap_min", gmin, 2);
        check_val("r37_gap_max", gmax, 3);
        check_val("r77_count", c1, 70);

        // Invalid load (DIV=0), then recovery
        set_ch(0, 2, 10, 0);
        set_ch(1, 5, 0, 0);
        step(1'b0, 1'b1);
        check_val("bad_cfg_err", CFG_ERR, 1);
        check_val("bad_status", STATUS, 3);
        check_val("bad_locked", LOCKED, 0);
        repeat (5) step(1'b0, 1'b0);
        set_ch(0, 1, 4, 0);
        set_ch(1, 2, 3, 0);
        step(1'b0, 1'b1);
        check_val("recover_err", CFG_ERR, 0);
        check_val("recover_status", STATUS, 1);
        wait_lock("relock_after_err", 16);
        run_cycles(24, c0, c1, f0, gmin, gmax);
        check_val("r14_count", c0, 6);
        check_val("r23_count", c1, 16);

        // RESET wins over a simultaneous CFG_LOAD
        set_ch(0, 1, 1, 0);
        set_ch(1, 1, 1, 0);
        step(1'b1, 1'b1);
        check_val("rst_win_status", STATUS, 0);
        check_val("rst_win_err", CFG_ERR, 0);
        wait_lock("lock_after_rst_win", 16);
        run_cycles(100, c0, c1, f0, gmin, gmax);
        check_val("rst_win_default", c0, 20);

        // MULT=0 never fires
        set_ch(0, 0, 5, 0);
        set_ch(1, 5, 5, 0);
        step(1'b0, 1'b1);
        wait_lock("lock_mult0", 16);
        run_cycles(1000, c0, c1, f0, gmin, gmax);
        check_val("mult0_count", c0, 0);
        check_val("mult0_locked", LOCKED, 1);
        check_val("div5_full_rate", c1, 1000);

        // Full-width ratios
        set_ch(0, 65535, 65535, 0);
        set_ch(1, 65534, 65535, 0);
        step(1'b0, 1'b1);
        wait_lock("lock_wide", 16);
        run_cycles(200, c0, c1, f0, gmin, gmax);
        check_val("wide_full", c0, 200);
        check_val("wide_almost", c1, 199);

        // MULT > DIV is rejected
        set_ch(0, 6, 5, 0);
        set_ch(1, 1, 2, 0);
        step(1'b0, 1'b1);
        check_val("mult_gt_div_err", CFG_ERR, 1);

        // Random loads, resets and run lengths
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                step(1'b1, 1'b0);
            end else begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    if ($urandom_range(0, 7) == 0) begin
                        d = $urandom_range(60000, 65535);
                        m = $urandom_range(0, d);
                    end else begin
                        d = $urandom_range(0, 12);
                        m = $urandom_range(0, d + 1);
                    end
                    p = (d == 0) ? 0 : $urandom_range(0, d);
                    set_ch(ch, m, d, p);
                end
                step(1'b0, 1'b1);
            end
            repeat ($urandom_range(0, 60)) step(1'b0, 1'b0);
        end

`ifdef CE_PHASE_EN
        set_ch(0, 2, 10, 8);
        set_ch(1, 1, 2, 0);
        step(1'b0, 1'b1);
        wait_lock("lock_phase", 16);
        step(1'b0, 1'b0);
        check_val("phase_first_ce", CE_OUT[0], 1);
        set_ch(0, 2, 10, 10);
        step(1'b0, 1'b1);
        check_val("phase_eq_div_err", CFG_ERR, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
